rst_req_ctrl: RTL and testbench

- Initiator side of the cross-domain reset handshake; drives the active-low reset input of a target domain's reset synchronizer.
- Generates a stretched reset pulse on power-up and on each system request.
- Holds the pulse until the target domain acknowledges entering reset, then releases it and waits for the acknowledge to drop.
- Reports completion or timeout to the system controller. Sits in the system-controller clock domain.

---
 rtl/rst_req_ctrl.sv | 132 +++++++++++++
 tb/tb_rst_req_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Initiator side of a cross-domain reset handshake: stretches an active-low reset
// pulse into a target domain, waits for its ack to rise and fall, and reports Done or Error.
module rst_req_ctrl #(
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic Req,
    input  logic Rst_Ack,
    output logic Domain_RST_n,
    output logic Busy,
    output logic Done,
    output logic Error
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ASSERT   = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [NUM_STAGES-1:0] r_sync;
    logic                  r_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  w_ack_s;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_ack_s   = r_sync[NUM_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], Rst_Ack};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_rst_n <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (Req) begin
                        r_state <= S_ASSERT;
                        r_rst_n <= 1'b0;
                        r_busy  <= 1'b1;
                        r_error <= 1'b0;
                    end else begin
                        r_rst_n <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_ASSERT: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_cnt <= '0;
                        // An ack that is already high is taken on the WAIT_ACK entry edge,
                        // so the low pulse is exactly PULSE_CYCLES long.
                        if (w_ack_s) begin
                            r_state <= S_RELEASE;
                            r_rst_n <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_ACK;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_s) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                        r_rst_n <= 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_rst_n <= 1'b1;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RELEASE: begin
                    if (!w_ack_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_rst_n <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Domain_RST_n = r_rst_n;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Error        = r_error;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl: power-on, request, both timeouts, Req while busy,
// back-to-back requests and mid-sequence reset, with hand-computed cycle counts.
module tb_rst_req_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic Req;
    logic Rst_Ack;
    logic Domain_RST_n;
    logic Busy;
    logic Done;
    logic Error;

    logic ack_val;
    logic mode;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    rst_req_ctrl #(
        .NUM_STAGES    (2),
        .PULSE_CYCLES  (8),
        .TIMEOUT_CYCLES(255),
        .CNT_WIDTH     (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Req         (Req),
        .Rst_Ack     (Rst_Ack),
        .Domain_RST_n(Domain_RST_n),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    // Target-domain model: ack follows the inverted reset through two flops.
    always @(posedge CLK) begin
        d1 <= ~Domain_RST_n;
        d2 <= d1;
    end
    assign Rst_Ack = mode ? d2 : ack_val;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Runs until Busy falls; scripts ack_val (manual mode) and Req per cycle.
    task automatic observe(input int max_cyc, input int rise_at, input int fall_after,
                           input logic [63:0] req_mask, output int low, output int dones,
                           output int cyc, output bit fin);
        int rel;
        rel   = -1;
        low   = (Domain_RST_n === 1'b0) ? 1 : 0;
        dones = 0;
        cyc   = 0;
        fin   = 1'b0;
        while (cyc < max_cyc && !fin) begin
            tick();
            cyc++;
            Req = (cyc < 64) ? req_mask[cyc] : 1'b0;
            if (rise_at >= 0 && cyc == rise_at) ack_val = 1'b1;
            if (Domain_RST_n === 1'b0) low++;
            if (Domain_RST_n === 1'b1 && rel < 0) rel = cyc;
            if (fall_after >= 0 && rel >= 0 && cyc == rel + fall_after) ack_val = 1'b0;
            if (Done === 1'b1) dones++;
            if (Busy === 1'b0) fin = 1'b1;
        end
        Req = 1'b0;
    endtask

    task automatic test_reset;
        int low, dones, cyc;
        bit fin;
        RST = 1'b1; Req = 1'b0; mode = 1'b0; ack_val = 1'b0;
        repeat (3) tick();
        n_cmp++; if (Domain_RST_n !== 1'b0) begin n_fail++; $display("FAIL reset_rst_n: got %b expected 0", Domain_RST_n); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
        n_cmp++; if (Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", Error); end
        RST = 1'b0;
        observe(100, 3, 4, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL poweron_finish: got %b expected 1", fin); end
        n_cmp++; if (low !== 8) begin n_fail++; $display("FAIL poweron_low: got %0d expected 8", low); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL poweron_dones: got %0d expected 1", dones); end
        n_cmp++; if (cyc !== 15) begin n_fail++; $display("FAIL poweron_cycles: got %0d expected 15", cyc); end
        n_cmp++; if (Done !== 1'b1) begin n_fail++; $display("FAIL poweron_done_with_busy: got %b expected 1", Done); end
        n_cmp++; if (Error !== 1'b0) begin n_fail++; $display("FAIL poweron_error: got %b expected 0", Error); end
        tick();
        n_cmp++; if (Done !== 1'b0) begin n_fail++; $display("FAIL poweron_done_pulse: got %b expected 0", Done); end
        n_cmp++; if (Domain_RST_n !== 1'b1) begin n_fail++; $display("FAIL poweron_idle_rst_n: got %b expected 1", Domain_RST_n); end
    endtask

    task automatic test_request;
        int low, dones, cyc;
        bit fin;
        mode = 1'b1;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        n_cmp++; if (Domain_RST_n !== 1'b0) begin n_fail++; $display("FAIL req_accept_rst_n: got %b expected 0", Domain_RST_n); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL req_accept_busy: got %b expected 1", Busy); end
        observe(100, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL req_finish: got %b expected 1", fin); end
        n_cmp++; if (low !== 8) begin n_fail++; $display("FAIL req_low: got %0d expected 8", low); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL req_dones: got %0d expected 1", dones); end
        n_cmp++; if (cyc !== 13) begin n_fail++; $display("FAIL req_cycles: got %0d expected 13", cyc); end
        tick();
        n_cmp++; if (Done !== 1'b0) begin n_fail++; $display("FAIL req_done_pulse: got %b expected 0", Done); end
    endtask

    task automatic test_ack_timeout;
        int low, dones, cyc;
        bit fin;
        mode = 1'b0; ack_val = 1'b0;
        repeat (3) tick();
        Req = 1'b1;
        tick();
        Req = 1'b0;
        observe(400, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL ackto_finish: got %b expected 1", fin); end
        n_cmp++; if (low !== 263) begin n_fail++; $display("FAIL ackto_low: got %0d expected 263", low); end
        n_cmp++; if (cyc !== 263) begin n_fail++; $display("FAIL ackto_cycles: got %0d expected 263", cyc); end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL ackto_dones: got %0d expected 0", dones); end
        n_cmp++; if (Error !== 1'b1) begin n_fail++; $display("FAIL ackto_error: got %b expected 1", Error); end
        n_cmp++; if (Domain_RST_n !== 1'b1) begin n_fail++; $display("FAIL ackto_rst_n: got %b expected 1", Domain_RST_n); end
        repeat (2) tick();
        n_cmp++; if (Error !== 1'b1) begin n_fail++; $display("FAIL ackto_sticky: got %b expected 1", Error); end
        mode = 1'b1;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        n_cmp++; if (Error !== 1'b0) begin n_fail++; $display("FAIL ackto_clear: got %b expected 0", Error); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL ackto_reaccept: got %b expected 1", Busy); end
        observe(100, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL ackto_recover_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_release_timeout;
        int low, dones, cyc;
        bit fin;
        mode = 1'b0; ack_val = 1'b1;
        repeat (3) tick();
        Req = 1'b1;
        tick();
        Req = 1'b0;
        observe(400, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL relto_finish: got %b expected 1", fin); end
        n_cmp++; if (low !== 8) begin n_fail++; $display("FAIL relto_low: got %0d expected 8", low); end
        n_cmp++; if (cyc !== 263) begin n_fail++; $display("FAIL relto_cycles: got %0d expected 263", cyc); end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL relto_dones: got %0d expected 0", dones); end
        n_cmp++; if (Error !== 1'b1) begin n_fail++; $display("FAIL relto_error: got %b expected 1", Error); end
        ack_val = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_req_during_busy;
        int low, dones, cyc;
        bit fin;
        logic [63:0] mask;
        mode = 1'b1;
        mask = '0;
        mask[2] = 1'b1;
        mask[5] = 1'b1;
        mask[9] = 1'b1;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        observe(100, -1, -1, mask, low, dones, cyc, fin);
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL busyreq_dones: got %0d expected 1", dones); end
        n_cmp++; if (low !== 8) begin n_fail++; $display("FAIL busyreq_low: got %0d expected 8", low); end
        n_cmp++; if (cyc !== 13) begin n_fail++; $display("FAIL busyreq_cycles: got %0d expected 13", cyc); end
        repeat (2) tick();
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL busyreq_not_queued: got %b expected 0", Busy); end
    endtask

    task automatic test_back_to_back;
        int low, dones, cyc, idles, bad;
        bit fin;
        mode = 1'b1;
        dones = 0; idles = 0; bad = 0;
        Req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done === 1'b1) dones++;
            if (Busy === 1'b0) idles++;
            if (Done === 1'b1 && Busy !== 1'b0) bad++;
        end
        Req = 1'b0;
        n_cmp++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
        n_cmp++; if (idles !== 2) begin n_fail++; $display("FAIL b2b_idle_gaps: got %0d expected 2", idles); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_done_busy: got %0d expected 0", bad); end
        observe(100, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_third_cycles: got %0d expected 2", cyc); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL b2b_third_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_mid_rst;
        int low, dones, cyc;
        bit fin;
        mode = 1'b1;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        repeat (9) tick();
        n_cmp++; if (Domain_RST_n !== 1'b1) begin n_fail++; $display("FAIL midrst_in_release: got %b expected 1", Domain_RST_n); end
        RST = 1'b1;
        #1;
        n_cmp++; if (Domain_RST_n !== 1'b0) begin n_fail++; $display("FAIL midrst_async_rst_n: got %b expected 0", Domain_RST_n); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL midrst_async_busy: got %b expected 1", Busy); end
        tick();
        RST = 1'b0;
        observe(100, -1, -1, 64'h0, low, dones, cyc, fin);
        n_cmp++; if (low !== 8) begin n_fail++; $display("FAIL midrst_low: got %0d expected 8", low); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL midrst_dones: got %0d expected 1", dones); end
        n_cmp++; if (cyc !== 13) begin n_fail++; $display("FAIL midrst_cycles: got %0d expected 13", cyc); end
        n_cmp++; if (Error !== 1'b0) begin n_fail++; $display("FAIL midrst_error: got %b expected 0", Error); end
    endtask

    initial begin
        test_reset();
        test_request();
        test_ack_timeout();
        test_release_timeout();
        test_req_during_busy();
        test_back_to_back();
        test_mid_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
